pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic.sv | 110 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register between core stages, with an optional two-entry skid
// buffer and an all-zero control word (bubble) whenever the head slot is empty.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W      = 160,
    parameter int unsigned CTRL_W      = 24,
    parameter bit          SKID        = 1'b1,
    parameter bit          CLR_ON_FLSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic accept;
    logic consume;

    // With the skid buffer, in_ready comes straight from a flop: no path from out_ready.
    assign in_ready = SKID ? !skid_v_q : (!main_v_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = main_v_q && out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (CLR_ON_FLSH) begin
                main_data_d = '0;
                main_ctrl_d = '0;
                skid_data_d = '0;
                skid_ctrl_d = '0;
            end
        end else if (SKID) begin
            if (!main_v_q || consume) begin
                // Skid entry is older than anything on the input, so it moves up first.
                if (skid_v_q) begin
                    main_v_d    = 1'b1;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_v_d    = 1'b0;
                end else begin
                    main_v_d = accept;
                    if (accept) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
            end else if (accept) begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end
        end else begin
            if (accept) begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else if (consume) begin
                main_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
    assign occupancy = 2'(main_v_q) + 2'(skid_v_q);

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) skid_v_q |-> main_v_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and scoreboarded checks of pipe_stage_elastic in skid (s_) and single-entry (n_) forms.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [DW-1:0] s_out_data, n_out_data;
    logic [CW-1:0] s_out_ctrl, n_out_ctrl;
    logic [1:0]    s_occ, n_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return d[CW-1:0] | 8'h80;
    endfunction

    assign in_ctrl = ctrl_of(in_data);

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CLR_ON_FLSH(1'b0)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_ctrl(s_out_ctrl), .occupancy(s_occ)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CLR_ON_FLSH(1'b1)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .out_ctrl(n_out_ctrl), .occupancy(n_occ)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Set inputs at the falling edge; they are captured at the following rising edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    logic [DW-1:0] sq[$];
    logic [DW-1:0] nq[$];
    logic          s_exp_rdy, n_exp_rdy;
    logic [DW-1:0] seq;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;

        // T1: reset holds everything empty despite a pending input
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("rst_s_valid", 64'(s_out_valid), 64'd0);
            check_eq("rst_s_ctrl", 64'(s_out_ctrl), 64'd0);
            check_eq("rst_s_data", 64'(s_out_data), 64'd0);
            check_eq("rst_s_ready", 64'(s_in_ready), 64'd1);
            check_eq("rst_s_occ", 64'(s_occ), 64'd0);
            check_eq("rst_n_ready", 64'(n_in_ready), 64'd1);
            check_eq("rst_n_occ", 64'(n_occ), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // T2: back-to-back stream 1..8, one-cycle latency on both variants
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); #1;
            if (i > 1) begin
                check_eq("str_s_valid", 64'(s_out_valid), 64'd1);
                check_eq("str_s_data", 64'(s_out_data), 64'(i - 1));
                check_eq("str_s_ctrl", 64'(s_out_ctrl), 64'(ctrl_of(32'(i - 1))));
                check_eq("str_n_data", 64'(n_out_data), 64'(i - 1));
            end
            check_eq("str_s_ready", 64'(s_in_ready), 64'd1);
            in_valid = (i <= 8); in_data = 32'(i); out_ready = 1'b1;
        end
        @(negedge clk); #1;
        check_eq("str_s_empty", 64'(s_out_valid), 64'd0);
        check_eq("str_s_bubble", 64'(s_out_ctrl), 64'd0);
        check_eq("str_n_empty", 64'(n_out_valid), 64'd0);

        // T3: backpressure fills the skid entry; drains in order
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        check_eq("bp_s_occ1", 64'(s_occ), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("bp_s_occ2", 64'(s_occ), 64'd2);
        check_eq("bp_s_ready0", 64'(s_in_ready), 64'd0);
        check_eq("bp_s_dataA", 64'(s_out_data), 64'hA);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_s_stableA", 64'(s_out_data), 64'hA);
        check_eq("bp_s_ctrlA", 64'(s_out_ctrl), 64'(ctrl_of(32'hA)));
        check_eq("bp_s_ready_held", 64'(s_in_ready), 64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_s_dataB", 64'(s_out_data), 64'hB);
        check_eq("bp_s_occB", 64'(s_occ), 64'd1);
        check_eq("bp_s_ready1", 64'(s_in_ready), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_s_drained", 64'(s_out_valid), 64'd0);
        check_eq("bp_s_occ0", 64'(s_occ), 64'd0);

        // T4: flush with a full skid stage and an offered 0xC
        drive(1'b1, 32'h1A, 1'b0, 1'b0);
        drive(1'b1, 32'h1B, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        check_eq("fl_s_occ_pre", 64'(s_occ), 64'd2);
        check_eq("fl_n_occ_pre", 64'(n_occ), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("fl_s_valid", 64'(s_out_valid), 64'd0);
        check_eq("fl_s_ctrl", 64'(s_out_ctrl), 64'd0);
        check_eq("fl_s_occ", 64'(s_occ), 64'd0);
        check_eq("fl_s_held_data", 64'(s_out_data), 64'h1A);
        check_eq("fl_n_occ", 64'(n_occ), 64'd0);
        check_eq("fl_n_cleared", 64'(n_out_data), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check_eq("fl_s_noC", 64'(s_out_valid), 64'd0);
        end

        // T5: single-entry in_ready follows out_ready combinationally; replace with no bubble
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        check_eq("ns_ready0", 64'(n_in_ready), 64'd0);
        check_eq("ns_head21", 64'(n_out_data), 64'h21);
        out_ready = 1'b1; #1;
        check_eq("ns_ready1", 64'(n_in_ready), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("ns_valid22", 64'(n_out_valid), 64'd1);
        check_eq("ns_head22", 64'(n_out_data), 64'h22);
        check_eq("ns_ctrl22", 64'(n_out_ctrl), 64'(ctrl_of(32'h22)));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("ns_empty", 64'(n_out_valid), 64'd0);
        check_eq("ns_s_empty", 64'(s_out_valid), 64'd0);

        // T6: random traffic against queue scoreboards
        seq = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, seq, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            seq = seq + 1;
            s_exp_rdy = (sq.size() < 2);
            n_exp_rdy = (nq.size() == 0) || out_ready;
            check_eq("rnd_s_ready", 64'(s_in_ready), 64'(s_exp_rdy));
            check_eq("rnd_n_ready", 64'(n_in_ready), 64'(n_exp_rdy));
            check_eq("rnd_s_occ", 64'(s_occ), 64'(sq.size()));
            check_eq("rnd_n_occ", 64'(n_occ), 64'(nq.size()));
            check_eq("rnd_s_valid", 64'(s_out_valid), 64'(sq.size() != 0));
            check_eq("rnd_n_valid", 64'(n_out_valid), 64'(nq.size() != 0));
            if (sq.size() != 0) begin
                check_eq("rnd_s_data", 64'(s_out_data), 64'(sq[0]));
                check_eq("rnd_s_ctrl", 64'(s_out_ctrl), 64'(ctrl_of(sq[0])));
            end else begin
                check_eq("rnd_s_bubble", 64'(s_out_ctrl), 64'd0);
            end
            if (nq.size() != 0) begin
                check_eq("rnd_n_data", 64'(n_out_data), 64'(nq[0]));
            end else begin
                check_eq("rnd_n_bubble", 64'(n_out_ctrl), 64'd0);
            end
            if (flush) begin
                sq.delete();
                nq.delete();
            end else begin
                if (sq.size() != 0 && out_ready) void'(sq.pop_front());
                if (in_valid && s_exp_rdy) sq.push_back(in_data);
                if (nq.size() != 0 && out_ready) void'(nq.pop_front());
                if (in_valid && n_exp_rdy) nq.push_back(in_data);
            end
        end

        // Reset mid-stream takes effect without waiting for a clock edge
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        drive(1'b1, 32'h78, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_s_occ", 64'(s_occ), 64'd0);
        check_eq("arst_s_valid", 64'(s_out_valid), 64'd0);
        check_eq("arst_n_occ", 64'(n_occ), 64'd0);
        check_eq("arst_s_ready", 64'(s_in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
